// File: rtl/bdi_pkg.sv
// Shared BDI definitions: encoding codes, base/delta size lookups, FSM states.
// Used by the line decompressor and its per-lane word expander.
package bdi_pkg;

  localparam logic [3:0] ENC_ZEROS  = 4'd0;
  localparam logic [3:0] ENC_REP8   = 4'd1;
  localparam logic [3:0] ENC_B8D1   = 4'd2;
  localparam logic [3:0] ENC_B8D2   = 4'd3;
  localparam logic [3:0] ENC_B8D4   = 4'd4;
  localparam logic [3:0] ENC_B4D1   = 4'd5;
  localparam logic [3:0] ENC_B4D2   = 4'd6;
  localparam logic [3:0] ENC_B2D1   = 4'd7;
  localparam logic [3:0] ENC_UNCOMP = 4'd15;

  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_HOLD} bdi_state_e;

  function automatic logic is_delta_enc(input logic [3:0] enc);
    return (enc >= ENC_B8D1) && (enc <= ENC_B2D1);
  endfunction

  function automatic logic is_legal_enc(input logic [3:0] enc);
    return (enc <= ENC_B2D1) || (enc == ENC_UNCOMP);
  endfunction

  // log2 of the base (word) size; non-delta codes report 8-byte words
  function automatic int base_shift(input logic [3:0] enc);
    case (enc)
      ENC_B4D1, ENC_B4D2: return 2;
      ENC_B2D1:           return 1;
      default:            return 3;
    endcase
  endfunction

  function automatic int delta_bytes(input logic [3:0] enc);
    case (enc)
      ENC_B8D2, ENC_B4D2: return 2;
      ENC_B8D4:           return 4;
      default:            return 1;
    endcase
  endfunction

endpackage

// File: rtl/bdi_lane_expand.sv
// Combinational single-word expander: optional base plus sign-extended delta,
// truncated to the word size. No state, no latency, no flow control.
module bdi_lane_expand (
  input  logic [63:0] base,
  input  logic [63:0] delta,
  input  logic        mask_bit,
  input  logic [3:0]  b_bytes,
  input  logic [3:0]  d_bytes,
  output logic [63:0] word
);

  logic [63:0] dext;
  logic [63:0] sum;

  always_comb begin
    case (d_bytes)
      4'd1:    dext = {{56{delta[7]}},  delta[7:0]};
      4'd2:    dext = {{48{delta[15]}}, delta[15:0]};
      4'd4:    dext = {{32{delta[31]}}, delta[31:0]};
      default: dext = delta;
    endcase
    sum = (mask_bit ? base : 64'd0) + dext;
    case (b_bytes)
      4'd2:    word = {48'd0, sum[15:0]};
      4'd4:    word = {32'd0, sum[31:0]};
      default: word = sum;
    endcase
  end

endmodule

// File: rtl/bdi_line_decompressor.sv
// BDI line decompressor: IDLE accepts, EXPAND writes LANES words/cycle in place, HOLD presents.
// Latency ceil(N/LANES)+1; output held stable under backpressure, no input taken until IDLE.
module bdi_line_decompressor
  import bdi_pkg::*;
#(
  parameter int LINE_BYTES = 32,
  parameter int LANES      = 4,
  parameter int ERR_ZERO   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_enc,
  input  logic [LINE_BYTES/2-1:0]   in_mask,
  input  logic [LINE_BYTES*8-1:0]   in_payload,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LINE_BYTES*8-1:0]   out_line,
  output logic                      out_err
);

  localparam int LW = LINE_BYTES * 8;
  localparam int MW = LINE_BYTES / 2;

  bdi_state_e        state_q, state_d;
  logic [3:0]        enc_q, enc_d;
  logic [MW-1:0]     mask_q, mask_d;
  logic [LW-1:0]     payload_q, payload_d;
  logic [7:0]        idx_q, idx_d;
  logic [LW-1:0]     line_q, line_d;
  logic              err_q, err_d;

  int b_bytes, d_bytes, nw;
  logic [63:0] lane_delta [LANES];
  logic        lane_mask  [LANES];
  logic [63:0] lane_word  [LANES];

  assign b_bytes = 1 << base_shift(enc_q);
  assign d_bytes = delta_bytes(enc_q);
  assign nw      = LINE_BYTES >> base_shift(enc_q);

  // Gather each lane's delta bytes; lanes past the last word stay idle
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_mask[l]  = 1'b0;
      lane_delta[l] = '0;
      if (int'(idx_q) + l < nw) begin
        lane_mask[l] = mask_q[int'(idx_q) + l];
        for (int j = 0; j < 8; j++) begin
          if (j < d_bytes && b_bytes + d_bytes * (int'(idx_q) + l) + j < LINE_BYTES)
            lane_delta[l][j*8 +: 8] = payload_q[(b_bytes + d_bytes * (int'(idx_q) + l) + j) * 8 +: 8];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bdi_lane_expand u_lane (
      .base     (payload_q[63:0]),
      .delta    (lane_delta[l]),
      .mask_bit (lane_mask[l]),
      .b_bytes  (4'(b_bytes)),
      .d_bytes  (4'(d_bytes)),
      .word     (lane_word[l])
    );
  end

  always_comb begin
    state_d   = state_q;
    enc_d     = enc_q;
    mask_d    = mask_q;
    payload_d = payload_q;
    idx_d     = idx_q;
    line_d    = line_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          enc_d     = in_enc;
          mask_d    = in_mask;
          payload_d = in_payload;
          idx_d     = '0;
          state_d   = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        err_d   = 1'b0;
        state_d = ST_HOLD;
        if (!is_legal_enc(enc_q)) begin
          err_d = 1'b1;
          if (ERR_ZERO != 0) line_d = '0;
        end else if (enc_q == ENC_ZEROS) begin
          line_d = '0;
        end else if (enc_q == ENC_REP8) begin
          for (int c = 0; c < LINE_BYTES / 8; c++) line_d[c*64 +: 64] = payload_q[63:0];
        end else if (enc_q == ENC_UNCOMP) begin
          line_d = payload_q;
        end else if (is_delta_enc(enc_q)) begin
          // Only the slots of this cycle's words are touched
          for (int l = 0; l < LANES; l++) begin
            if (int'(idx_q) + l < nw) begin
              for (int j = 0; j < 8; j++) begin
                if (j < b_bytes)
                  line_d[((int'(idx_q) + l) * b_bytes + j) * 8 +: 8] = lane_word[l][j*8 +: 8];
              end
            end
          end
          if (int'(idx_q) + LANES < nw) begin
            state_d = ST_EXPAND;
            idx_d   = idx_q + 8'(LANES);
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      enc_q     <= '0;
      mask_q    <= '0;
      payload_q <= '0;
      idx_q     <= '0;
      line_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      enc_q     <= enc_d;
      mask_q    <= mask_d;
      payload_q <= payload_d;
      idx_q     <= idx_d;
      line_q    <= line_d;
      err_q     <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign out_line  = line_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_bdi_line_decompressor.sv
// Bench for bdi_line_decompressor: directed table, backpressure and reset sequences,
// plus random lines on three parameterisations checked against a byte-level model.
module tb_bdi_line_decompressor;

  logic clk;
  logic rst;

  logic         i_valid [3];
  logic         i_ready [3];
  logic [3:0]   i_enc   [3];
  logic [31:0]  i_mask  [3];
  logic [511:0] i_pay   [3];
  logic         o_valid [3];
  logic         o_rdy   [3];
  logic         o_err   [3];
  logic [511:0] o_line  [3];

  logic [255:0] line0;
  logic [511:0] line1;
  logic [127:0] line2;

  int checks = 0;
  int errors = 0;

  bdi_line_decompressor #(.LINE_BYTES(32), .LANES(4), .ERR_ZERO(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(i_valid[0]), .in_ready(i_ready[0]), .in_enc(i_enc[0]),
    .in_mask(i_mask[0][15:0]), .in_payload(i_pay[0][255:0]), .out_valid(o_valid[0]),
    .out_ready(o_rdy[0]), .out_line(line0), .out_err(o_err[0]));

  bdi_line_decompressor #(.LINE_BYTES(64), .LANES(1), .ERR_ZERO(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(i_valid[1]), .in_ready(i_ready[1]), .in_enc(i_enc[1]),
    .in_mask(i_mask[1][31:0]), .in_payload(i_pay[1][511:0]), .out_valid(o_valid[1]),
    .out_ready(o_rdy[1]), .out_line(line1), .out_err(o_err[1]));

  bdi_line_decompressor #(.LINE_BYTES(16), .LANES(8), .ERR_ZERO(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(i_valid[2]), .in_ready(i_ready[2]), .in_enc(i_enc[2]),
    .in_mask(i_mask[2][7:0]), .in_payload(i_pay[2][127:0]), .out_valid(o_valid[2]),
    .out_ready(o_rdy[2]), .out_line(line2), .out_err(o_err[2]));

  assign o_line[0] = {256'd0, line0};
  assign o_line[1] = line1;
  assign o_line[2] = {384'd0, line2};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int inst_lb(input int inst);
    return (inst == 0) ? 32 : (inst == 1) ? 64 : 16;
  endfunction

  function automatic int inst_lanes(input int inst);
    return (inst == 0) ? 4 : (inst == 1) ? 1 : 8;
  endfunction

  // Word/delta sizes straight from the encoding table; 0 means not a delta code
  function automatic int enc_b(input logic [3:0] enc);
    case (enc)
      4'd2, 4'd3, 4'd4: return 8;
      4'd5, 4'd6:       return 4;
      4'd7:             return 2;
      default:          return 0;
    endcase
  endfunction

  function automatic int enc_d(input logic [3:0] enc);
    case (enc)
      4'd3, 4'd6: return 2;
      4'd4:       return 4;
      default:    return 1;
    endcase
  endfunction

  function automatic logic model_err(input logic [3:0] enc);
    return !(enc <= 4'd7 || enc == 4'd15);
  endfunction

  function automatic int model_lat(input int lb, input int lanes, input logic [3:0] enc);
    int n;
    n = (enc_b(enc) != 0) ? lb / enc_b(enc) : 1;
    return (n + lanes - 1) / lanes + 1;
  endfunction

  function automatic logic [511:0] model_line(input int lb, input logic [3:0] enc,
                                              input logic [31:0] mask, input logic [511:0] pay);
    logic [511:0] r;
    int bb, dd;
    longint base, dv, w;
    r  = '0;
    bb = enc_b(enc);
    dd = enc_d(enc);
    if (enc == 4'd1) begin
      for (int i = 0; i < lb; i++) r[i*8 +: 8] = pay[(i % 8)*8 +: 8];
    end else if (enc == 4'd15) begin
      for (int i = 0; i < lb; i++) r[i*8 +: 8] = pay[i*8 +: 8];
    end else if (bb != 0) begin
      base = 0;
      for (int j = 0; j < bb; j++) base |= longint'(pay[j*8 +: 8]) << (8*j);
      for (int k = 0; k < lb / bb; k++) begin
        dv = 0;
        for (int j = 0; j < dd; j++) dv |= longint'(pay[(bb + k*dd + j)*8 +: 8]) << (8*j);
        if (dv >= (longint'(1) << (8*dd - 1))) dv -= (longint'(1) << (8*dd));
        w = (mask[k] ? base : longint'(0)) + dv;
        for (int j = 0; j < bb; j++) r[(k*bb + j)*8 +: 8] = w[j*8 +: 8];
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the line handed off
  task automatic run_line(input int inst, input logic [3:0] enc, input logic [31:0] mask,
                          input logic [511:0] pay, input logic [511:0] exp_line,
                          input logic exp_err, input int exp_lat, input int hold,
                          input string name);
    int cyc;
    chk({name, ".in_ready"}, 512'(i_ready[inst]), 512'(1));
    i_valid[inst] = 1'b1;
    i_enc[inst]   = enc;
    i_mask[inst]  = mask;
    i_pay[inst]   = pay;
    @(posedge clk);
    #1;
    i_valid[inst] = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!o_valid[inst] && cyc < 60);
    chk({name, ".latency"}, 512'(cyc), 512'(exp_lat));
    chk({name, ".line"}, o_line[inst], exp_line);
    chk({name, ".err"}, 512'(o_err[inst]), 512'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, ".hold_line"}, o_line[inst], exp_line);
      chk({name, ".hold_flags"}, {o_valid[inst], i_ready[inst]}, 512'(2'b10));
    end
    o_rdy[inst] = 1'b1;
    @(posedge clk);
    #1;
    o_rdy[inst] = 1'b0;
    @(negedge clk);
    chk({name, ".after_hs"}, {o_valid[inst], i_ready[inst]}, 512'(2'b01));
  endtask

  typedef struct {
    logic [3:0]   enc;
    logic [31:0]  mask;
    logic [511:0] pay;
    logic [511:0] line;
    logic         err;
    int           lat;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [3:0]   renc;
    logic [31:0]  rmask;
    logic [511:0] rpay;
    int           lb;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_valid[i] = 1'b0;
      o_rdy[i]   = 1'b0;
      i_enc[i]   = '0;
      i_mask[i]  = '0;
      i_pay[i]   = '0;
    end

    vt[0] = '{4'd2, 32'h0000_FFFF, 512'(256'h7F00FF01_0000000000001000),
              512'(256'h000000000000107F_0000000000001000_0000000000000FFF_0000000000001001), 1'b0, 2};
    vt[1] = '{4'd7, 32'h0000_0001, 512'(256'h8003FFFE), 512'(256'hFF800001), 1'b0, 5};
    vt[2] = '{4'd9, 32'h0000_FFFF, 512'(256'hDEADBEEF_CAFEF00D), 512'd0, 1'b1, 2};
    vt[3] = '{4'd15, 32'h0, 512'({32{8'hA5}}), 512'({32{8'hA5}}), 1'b0, 2};
    vt[4] = '{4'd0, 32'hFFFF_FFFF, 512'(256'h1234_5678), 512'd0, 1'b0, 2};
    vt[5] = '{4'd1, 32'h0, 512'(64'h0123456789ABCDEF), 512'({4{64'h0123456789ABCDEF}}), 1'b0, 2};
    vt[6] = '{4'd6, 32'h0000_00AA, 512'(64'hFFFF0001_00010000),
              512'({32'h00010000, 32'h0, 32'h00010000, 32'h0, 32'h00010000, 32'h0, 32'h0000FFFF, 32'h00000001}),
              1'b0, 3};
    vt[7] = '{4'd4, 32'h0000_0003,
              512'(256'h00000000_7FFFFFFF_80000000_00000001_FFFFFFFFFFFFFFFF),
              512'({64'h0, 64'h000000007FFFFFFF, 64'hFFFFFFFF7FFFFFFF, 64'h0}), 1'b0, 2};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset.in_ready", 512'(i_ready[i]), 512'(1));
      chk("reset.out_valid", 512'(o_valid[i]), 512'(0));
      chk("reset.out_err", 512'(o_err[i]), 512'(0));
      chk("reset.out_line", o_line[i], 512'd0);
    end
    rst = 1'b0;

    for (int v = 0; v < 8; v++)
      run_line(0, vt[v].enc, vt[v].mask, vt[v].pay, vt[v].line, vt[v].err, vt[v].lat, 0,
               $sformatf("vec%0d", v));

    // Backpressure: ten stalled cycles before the consumer takes the line
    run_line(0, vt[0].enc, vt[0].mask, vt[0].pay, vt[0].line, 1'b0, 2, 10, "backpressure");

    // Reset in the middle of a 4-cycle B2D1 expansion
    i_valid[0] = 1'b1;
    i_enc[0]   = 4'd7;
    i_mask[0]  = 32'hFFFF;
    i_pay[0]   = 512'(256'h0102030405060708090A0B0C0D0E0F101112);
    @(posedge clk);
    #1;
    i_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midexp.busy", {o_valid[0], i_ready[0]}, 512'(2'b00));
    rst = 1'b1;
    #1;
    chk("midexp.rst_flags", {o_valid[0], i_ready[0], o_err[0]}, 512'(3'b010));
    chk("midexp.rst_line", o_line[0], 512'd0);
    @(negedge clk);
    rst = 1'b0;
    run_line(0, vt[0].enc, vt[0].mask, vt[0].pay, vt[0].line, 1'b0, 2, 0, "post_reset");

    // Random lines across all three parameterisations
    for (int inst = 0; inst < 3; inst++) begin
      lb = inst_lb(inst);
      for (int n = 0; n < 25; n++) begin
        case ($urandom_range(0, 10))
          0: renc = 4'd0;   1: renc = 4'd1;   2: renc = 4'd2;
          3: renc = 4'd3;   4: renc = 4'd4;   5: renc = 4'd5;
          6: renc = 4'd6;   7: renc = 4'd7;   8: renc = 4'd15;
          9: renc = 4'd9;   default: renc = 4'd12;
        endcase
        rmask = $urandom;
        for (int w = 0; w < 16; w++) rpay[w*32 +: 32] = $urandom;
        run_line(inst, renc, rmask, rpay, model_line(lb, renc, rmask, rpay), model_err(renc),
                 model_lat(lb, inst_lanes(inst), renc), $urandom_range(0, 2),
                 $sformatf("rand_i%0d_n%0d_e%0d", inst, n, renc));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bdi_line_decompressor.md
BDI_LINE_DECOMPRESSOR -- requirements
Module: bdi_line_decompressor

Interface
REQ-001 SHALL have parameter LINE_BYTES, default 32, giving the uncompressed line size in bytes; legal values are 16, 32 and 64.
REQ-002 SHALL have parameter LANES, default 4, giving the number of output words expanded per cycle; legal values are 1, 2, 4 and 8.
REQ-003 SHALL have parameter ERR_ZERO, default 1; when 1, an illegal encoding zero-fills the output line.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: a compressed line is presented.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a line this cycle.
REQ-008 SHALL have port in_enc, input, 4 bits: encoding code, defined in REQ-014.
REQ-009 SHALL have port in_mask, input, LINE_BYTES/2 bits: per-word base select; 1 selects the dynamic base, 0 selects the zero base.
REQ-010 SHALL have port in_payload, input, LINE_BYTES*8 bits: the base in the LSBs, followed by the deltas packed contiguously LSB-first.
REQ-011 SHALL have port out_valid, output, 1 bit: the decompressed line is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the line.
REQ-013 SHALL have ports out_line (output, LINE_BYTES*8 bits: decompressed line) and out_err (output, 1 bit: illegal encoding, qualified by out_valid).

Function
REQ-014 Encodings SHALL be as follows (base bytes B / delta bytes D):
- 0 = ZEROS
- 1 = REP8, an 8-byte value repeated
- 2 = B8D1, 3 = B8D2, 4 = B8D4
- 5 = B4D1, 6 = B4D2
- 7 = B2D1
- 15 = UNCOMP
- all other codes are illegal.
REQ-015 A transfer SHALL occur on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-016 The FSM SHALL have three states, IDLE -> EXPAND -> HOLD -> IDLE:
- in_ready = 1 only in IDLE;
- out_valid = 1 only in HOLD.
REQ-017 On input acceptance, in_enc, in_mask and in_payload SHALL be registered, the word index SHALL be cleared, and the FSM SHALL enter EXPAND.
REQ-018 In EXPAND, each cycle SHALL produce LANES words of size B, starting at the current index.
- Word k = mask[k] ? base + sext(delta_k) : sext(delta_k), computed modulo 2^(8B).
- delta_k is located at bit offset 8B + k*8D.
REQ-019 The word count SHALL be N = LINE_BYTES/B. EXPAND SHALL last ceil(N/LANES) cycles, after which the FSM enters HOLD.
- With defaults and B8D1: 1 cycle.
- With defaults and B2D1: 4 cycles.
REQ-020 ZEROS, REP8, UNCOMP and illegal encodings SHALL spend exactly 1 EXPAND cycle.
- UNCOMP copies in_payload to out_line.
- REP8 replicates payload[63:0] across the line.
REQ-021 Any delta field that would extend past the payload SHALL be a configuration error. Legal encodings never do this at the legal LINE_BYTES values. No runtime check is required.
REQ-022 An illegal encoding SHALL set out_err = 1 and, when ERR_ZERO = 1, set out_line = 0.
REQ-023 Latency SHALL be ceil(N/LANES) + 1 cycles from input acceptance to out_valid.
REQ-024 While out_valid = 1 and out_ready = 0, out_line and out_err SHALL be held stable.
REQ-025 A new input SHALL NOT be accepted in the same cycle as an output handshake. IDLE SHALL be re-entered first, giving a minimum of ceil(N/LANES) + 2 cycles per line.
REQ-026 out_line SHALL be assembled in place. Only the word slots being written in a cycle change; the other bits retain their prior values.

Reset
REQ-027 While rst = 1, the FSM SHALL be in IDLE, with in_ready = 1, out_valid = 0, out_err = 0, out_line = 0, and the index = 0.
REQ-028 Assertion of rst mid-EXPAND or mid-HOLD SHALL abandon the line; no partial output becomes visible after release.
REQ-029 The first input acceptance SHALL be possible in the first rising edge after rst deasserts.

Structure
REQ-030 Encoding codes, B/D lookup functions and FSM state encodings SHALL reside in the shared package bdi_pkg.
REQ-031 A combinational sub-module bdi_lane_expand SHALL compute a single word from the base, delta, mask bit, B and D; LANES instances of it SHALL be generated.

Verification
REQ-032 Reset mid-EXPAND SHALL be covered: assert rst during an EXPAND cycle -> next cycle IDLE, in_ready = 1, out_valid = 0, out_line = 0.
REQ-033 B8D1 SHALL be covered: base 0x1000, deltas +1, -1, 0, 0x7F, mask all 1s -> words 0x1001, 0x0FFF, 0x1000, 0x107F, with out_valid 2 cycles after acceptance.
REQ-034 B2D1 mixed-mask case SHALL be covered: base 0xFFFE, delta +3, mask bit 1 -> word 0x0001 (wrap). Mask bit 0 with delta 0x80 -> 0xFF80. out_valid arrives 5 cycles after acceptance.
REQ-035 Backpressure SHALL be covered: out_ready = 0 for 10 cycles -> out_line stable, in_ready = 0; out_ready = 1 -> handshake, then in_ready = 1 the next cycle.
REQ-036 Illegal encoding SHALL be covered: in_enc = 9 -> out_err = 1 and out_line = 0 after 2 cycles. UNCOMP with payload 0xA5..A5 -> out_line equal to payload, out_err = 0.
REQ-037 Parameter sweep SHALL be covered: LANES in {1, 8} and LINE_BYTES in {16, 64} with random legal lines -> results match the reference model and latency satisfies REQ-023.
